// File: rtl/data_cache_pkg.sv
// Shared definitions for the write-back data cache: width codes, FSM states and
// address-field sizing helpers.
package data_cache_pkg;

    localparam logic [2:0] WIDTH_B  = 3'b000;
    localparam logic [2:0] WIDTH_H  = 3'b001;
    localparam logic [2:0] WIDTH_W  = 3'b010;
    localparam logic [2:0] WIDTH_BU = 3'b100;
    localparam logic [2:0] WIDTH_HU = 3'b101;

    typedef enum logic [2:0] {
        StIdle,
        StLookup,
        StEvict,
        StRefill,
        StRespond
    } state_e;

    function automatic int unsigned offset_bits(input int unsigned line_bytes);
        return $clog2(line_bytes);
    endfunction

    function automatic int unsigned index_bits(input int unsigned num_lines);
        return $clog2(num_lines);
    endfunction

    function automatic int unsigned tag_bits(input int unsigned addr_width,
                                             input int unsigned num_lines,
                                             input int unsigned line_bytes);
        return addr_width - offset_bits(line_bytes) - index_bits(num_lines);
    endfunction

endpackage

// File: rtl/data_cache_wb_align.sv
// Load extract/extend, store byte merge and alignment/width fault detection for one
// 32-bit word.
module load_store_align
    import data_cache_pkg::*;
(
    input  logic [2:0]  width,
    input  logic [1:0]  byte_off,
    input  logic [31:0] wdata,
    input  logic [31:0] rword,
    output logic [31:0] load_data,
    output logic [31:0] store_word,
    output logic        fault
);

    logic [31:0] shifted;
    logic [31:0] wshift;
    logic [3:0]  be;

    assign shifted = rword >> {byte_off, 3'b000};
    assign wshift  = wdata << {byte_off, 3'b000};

    always_comb begin
        load_data = '0;
        be        = '0;
        fault     = 1'b0;
        case (width)
            WIDTH_B: begin
                load_data = {{24{shifted[7]}}, shifted[7:0]};
                be        = 4'b0001 << byte_off;
            end
            WIDTH_BU: begin
                load_data = {24'h0, shifted[7:0]};
                be        = 4'b0001 << byte_off;
            end
            WIDTH_H: begin
                load_data = {{16{shifted[15]}}, shifted[15:0]};
                be        = 4'b0011 << byte_off;
                fault     = byte_off[0];
            end
            WIDTH_HU: begin
                load_data = {16'h0, shifted[15:0]};
                be        = 4'b0011 << byte_off;
                fault     = byte_off[0];
            end
            WIDTH_W: begin
                load_data = rword;
                be        = 4'b1111;
                fault     = (byte_off != 2'b00);
            end
            default: fault = 1'b1;
        endcase
    end

    always_comb begin
        store_word = rword;
        for (int i = 0; i < 4; i++) begin
            if (be[i]) store_word[8*i +: 8] = wshift[8*i +: 8];
        end
    end

endmodule

// File: rtl/data_cache_wb.sv
// Direct-mapped write-back, write-allocate data cache with word-wide line refill and
// eviction towards a valid/ready backing memory.
module data_cache_wb
    import data_cache_pkg::*;
#(
    parameter int unsigned NUM_LINES  = 16,
    parameter int unsigned LINE_BYTES = 16,
    parameter int unsigned ADDR_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_write,
    input  logic [2:0]            req_width,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [31:0]           req_wdata,
    output logic                  resp_valid,
    output logic [31:0]           resp_rdata,
    output logic                  resp_fault,
    output logic                  mem_valid,
    input  logic                  mem_ready,
    output logic                  mem_write,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [31:0]           mem_wdata,
    input  logic                  mem_rvalid,
    input  logic [31:0]           mem_rdata
);

    localparam int unsigned OFF_W  = offset_bits(LINE_BYTES);
    localparam int unsigned IDX_W  = index_bits(NUM_LINES);
    localparam int unsigned TAG_W  = tag_bits(ADDR_WIDTH, NUM_LINES, LINE_BYTES);
    localparam int unsigned WORDS  = LINE_BYTES / 4;
    localparam int unsigned CNT_W  = $clog2(WORDS) + 1;
    localparam int unsigned WIDX_W = $clog2(NUM_LINES * WORDS);

    state_e                state_q, state_d;
    logic [CNT_W-1:0]      beat_q, beat_d, rcv_q, rcv_d;
    logic [NUM_LINES-1:0]  valid_q, valid_d, dirty_q, dirty_d;
    logic [31:0]           rdata_q, rdata_d;
    logic                  fault_q, fault_d;

    logic                  write_q;
    logic [2:0]            width_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [31:0]           wdata_q;
    logic                  capture;

    logic [31:0]           data_q [NUM_LINES*WORDS];
    logic [TAG_W-1:0]      tag_q [NUM_LINES];

    logic [TAG_W-1:0]      tag_req;
    logic [IDX_W-1:0]      idx;
    logic                  hit;
    logic [WIDX_W-1:0]     line_base, req_widx, beat_widx, rcv_widx;
    logic [ADDR_WIDTH-1:0] refill_base, evict_base, beat_off;

    logic                  data_we, tag_we;
    logic [WIDX_W-1:0]     data_waddr;
    logic [31:0]           data_wdata;

    logic [2:0]            al_width;
    logic [1:0]            al_off;
    logic [31:0]           rword, load_data, store_word;
    logic                  al_fault;

    assign tag_req     = addr_q[ADDR_WIDTH-1 -: TAG_W];
    assign idx         = addr_q[OFF_W +: IDX_W];
    assign hit         = valid_q[idx] && (tag_q[idx] == tag_req);
    assign line_base   = WIDX_W'(idx) * WIDX_W'(WORDS);
    assign req_widx    = line_base + WIDX_W'(addr_q[OFF_W-1:0] >> 2);
    assign beat_widx   = line_base + WIDX_W'(beat_q);
    assign rcv_widx    = line_base + WIDX_W'(rcv_q);
    assign refill_base = {tag_req, idx, {OFF_W{1'b0}}};
    assign evict_base  = {tag_q[idx], idx, {OFF_W{1'b0}}};
    assign beat_off    = ADDR_WIDTH'(beat_q) << 2;
    assign rword       = data_q[req_widx];

    // Fault check looks at the live request while idle, at the captured one afterwards.
    assign al_width = (state_q == StIdle) ? req_width : width_q;
    assign al_off   = (state_q == StIdle) ? req_addr[1:0] : addr_q[1:0];

    load_store_align u_align (
        .width      (al_width),
        .byte_off   (al_off),
        .wdata      (wdata_q),
        .rword      (rword),
        .load_data  (load_data),
        .store_word (store_word),
        .fault      (al_fault)
    );

    always_comb begin
        state_d    = state_q;
        beat_d     = beat_q;
        rcv_d      = rcv_q;
        valid_d    = valid_q;
        dirty_d    = dirty_q;
        rdata_d    = rdata_q;
        fault_d    = fault_q;
        capture    = 1'b0;
        req_ready  = 1'b0;
        resp_valid = 1'b0;
        mem_valid  = 1'b0;
        mem_write  = 1'b0;
        mem_addr   = refill_base + beat_off;
        mem_wdata  = '0;
        data_we    = 1'b0;
        data_waddr = req_widx;
        data_wdata = store_word;
        tag_we     = 1'b0;
        unique case (state_q)
            StIdle: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    capture = 1'b1;
                    rdata_d = '0;
                    fault_d = al_fault;
                    state_d = al_fault ? StRespond : StLookup;
                end
            end
            StLookup: begin
                beat_d = '0;
                rcv_d  = '0;
                if (hit) begin
                    if (write_q) begin
                        data_we      = 1'b1;
                        dirty_d[idx] = 1'b1;
                    end else begin
                        rdata_d = load_data;
                    end
                    state_d = StRespond;
                end else if (valid_q[idx] && dirty_q[idx]) begin
                    state_d = StEvict;
                end else begin
                    state_d = StRefill;
                end
            end
            StEvict: begin
                mem_valid = 1'b1;
                mem_write = 1'b1;
                mem_addr  = evict_base + beat_off;
                mem_wdata = data_q[beat_widx];
                if (mem_ready) begin
                    if (beat_q == CNT_W'(WORDS - 1)) begin
                        beat_d  = '0;
                        state_d = StRefill;
                    end else begin
                        beat_d = beat_q + 1'b1;
                    end
                end
            end
            StRefill: begin
                // Requests run ahead of returned data; the two counters are independent.
                mem_valid = (beat_q != CNT_W'(WORDS));
                if (mem_valid && mem_ready) beat_d = beat_q + 1'b1;
                if (mem_rvalid) begin
                    data_we    = 1'b1;
                    data_waddr = rcv_widx;
                    data_wdata = mem_rdata;
                    rcv_d      = rcv_q + 1'b1;
                    if (rcv_q == CNT_W'(WORDS - 1)) begin
                        tag_we       = 1'b1;
                        valid_d[idx] = 1'b1;
                        dirty_d[idx] = 1'b0;
                        state_d      = StLookup;
                    end
                end
            end
            StRespond: begin
                resp_valid = 1'b1;
                state_d    = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    assign resp_rdata = rdata_q;
    assign resp_fault = fault_q && (state_q == StRespond);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            beat_q  <= '0;
            rcv_q   <= '0;
            valid_q <= '0;
            dirty_q <= '0;
            rdata_q <= '0;
            fault_q <= 1'b0;
        end else begin
            state_q <= state_d;
            beat_q  <= beat_d;
            rcv_q   <= rcv_d;
            valid_q <= valid_d;
            dirty_q <= dirty_d;
            rdata_q <= rdata_d;
            fault_q <= fault_d;
        end
    end

    always_ff @(posedge clk) begin
        if (capture) begin
            write_q <= req_write;
            width_q <= req_width;
            addr_q  <= req_addr;
            wdata_q <= req_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (data_we) data_q[data_waddr] <= data_wdata;
        if (tag_we) tag_q[idx] <= tag_req;
    end

endmodule

// File: tb/tb_data_cache_wb.sv
// Self-checking bench for data_cache_wb: directed vector table, stall/reset sequences and
// random traffic against a flat-memory reference with a line-state model.
module tb_data_cache_wb;

    typedef logic [31:0] wmap_t [logic [31:0]];

    typedef struct {
        string       name;
        bit          wr;
        logic [2:0]  width;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
        bit          exp_fault;
        int          exp_lat;
        int          exp_rd;
        int          exp_wr;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0, req_write = 1'b0;
    logic [2:0]  req_width = 3'b0;
    logic [31:0] req_addr = '0, req_wdata = '0;
    logic        req_ready, resp_valid, resp_fault, mem_valid, mem_write;
    logic [31:0] resp_rdata, mem_addr, mem_wdata;
    logic        mem_ready = 1'b1, mem_rvalid = 1'b0;
    logic [31:0] mem_rdata = '0;

    int n_checks = 0;
    int n_fails  = 0;

    wmap_t       bmem, golden;
    logic [31:0] pend[$], rd_log[$], wr_log[$], wd_log[$];
    bit          ready_rand = 0, ready_block = 0;
    bit          mv[16], md[16];
    logic [23:0] mt[16];

    data_cache_wb dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_write  (req_write),
        .req_width  (req_width),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .resp_valid (resp_valid),
        .resp_rdata (resp_rdata),
        .resp_fault (resp_fault),
        .mem_valid  (mem_valid),
        .mem_ready  (mem_ready),
        .mem_write  (mem_write),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rvalid (mem_rvalid),
        .mem_rdata  (mem_rdata)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fails++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] init_word(input logic [31:0] a);
        case (a)
            32'h40:  return 32'h11223344;
            32'h44:  return 32'h55667788;
            32'h48:  return 32'h99AABBCC;
            32'h4C:  return 32'hDDEEFF00;
            default: return {~a[15:0], a[15:0]} ^ 32'h3C5A_96E1;
        endcase
    endfunction

    function automatic logic [31:0] bmem_rd(input logic [31:0] a);
        return bmem.exists(a) ? bmem[a] : init_word(a);
    endfunction

    function automatic logic [31:0] gold_rd(input logic [31:0] a);
        return golden.exists(a) ? golden[a] : init_word(a);
    endfunction

    // Backing memory: logs beats, returns refill data in order after random gaps.
    bit          stall_prev = 0, rst_seen;
    logic        sv_write;
    logic [31:0] sv_addr, sv_wdata;
    always @(posedge clk) begin
        rst_seen = rst;
        if (stall_prev && !rst) begin
            chk("mem_hold_valid", {31'b0, mem_valid}, 32'd1);
            chk("mem_hold_addr", mem_addr, sv_addr);
            chk("mem_hold_wdata", mem_wdata, sv_wdata);
            chk("mem_hold_write", {31'b0, mem_write}, {31'b0, sv_write});
        end
        stall_prev = mem_valid && !mem_ready && !rst;
        sv_addr = mem_addr; sv_wdata = mem_wdata; sv_write = mem_write;
        if (rst) begin
            pend.delete();
        end else if (mem_valid && mem_ready) begin
            if (mem_write) begin
                bmem[mem_addr] = mem_wdata;
                wr_log.push_back(mem_addr);
                wd_log.push_back(mem_wdata);
            end else begin
                rd_log.push_back(mem_addr);
                pend.push_back(mem_addr);
            end
        end
        #1;
        if (!rst_seen && pend.size() > 0 && $urandom_range(0, 3) != 0) begin
            mem_rvalid = 1'b1;
            mem_rdata  = bmem_rd(pend.pop_front());
        end else begin
            mem_rvalid = 1'b0;
            mem_rdata  = $urandom;
        end
        mem_ready = ready_block ? 1'b0 : (ready_rand ? 1'($urandom_range(0, 1)) : 1'b1);
    end

    task automatic model_reset();
        golden = bmem;
        for (int i = 0; i < 16; i++) begin mv[i] = 0; md[i] = 0; end
    endtask

    task automatic reset_dut();
        rst = 1'b1; req_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        model_reset();
    endtask

    task automatic do_req(input bit wr, input logic [2:0] wd, input logic [31:0] a,
                          input logic [31:0] wdat, output logic [31:0] rd, output logic flt,
                          output int lat, output int nrd, output int nwr);
        int r0, w0, g;
        r0 = rd_log.size(); w0 = wr_log.size(); g = 0;
        while (!req_ready && g < 100) begin @(posedge clk); #1; g++; end
        req_valid = 1'b1; req_write = wr; req_width = wd; req_addr = a; req_wdata = wdat;
        @(posedge clk); #1;
        req_valid = 1'b0; req_write = 1'($urandom); req_width = 3'($urandom);
        req_addr = $urandom; req_wdata = $urandom;
        lat = 1;
        while (!resp_valid && lat < 300) begin @(posedge clk); #1; lat++; end
        chk("resp_seen", {31'b0, resp_valid}, 32'd1);
        if (!resp_valid) lat = -1;
        rd = resp_rdata; flt = resp_fault;
        nrd = rd_log.size() - r0; nwr = wr_log.size() - w0;
    endtask

    function automatic bit ref_fault(input logic [2:0] wd, input logic [31:0] a);
        case (wd)
            3'b000, 3'b100: return 0;
            3'b001, 3'b101: return a[0];
            3'b010:         return a[1:0] != 2'b00;
            default:        return 1;
        endcase
    endfunction

    function automatic logic [31:0] ref_load(input logic [2:0] wd, input logic [31:0] a);
        logic [31:0] w;
        w = gold_rd({a[31:2], 2'b00}) >> (8 * a[1:0]);
        case (wd)
            3'b000:  return {{24{w[7]}}, w[7:0]};
            3'b100:  return {24'h0, w[7:0]};
            3'b001:  return {{16{w[15]}}, w[15:0]};
            3'b101:  return {16'h0, w[15:0]};
            default: return w;
        endcase
    endfunction

    task automatic ref_store(input logic [2:0] wd, input logic [31:0] a, input logic [31:0] d);
        logic [31:0] w;
        int sz;
        w  = gold_rd({a[31:2], 2'b00});
        sz = (wd[1:0] == 2'b00) ? 1 : (wd[1:0] == 2'b01) ? 2 : 4;
        for (int b = 0; b < 4; b++)
            if (b >= a[1:0] && b < a[1:0] + sz) w[8*b +: 8] = d[8*(b - a[1:0]) +: 8];
        golden[{a[31:2], 2'b00}] = w;
    endtask

    vec_t        vecs[$];
    logic [31:0] rd;
    logic        flt;
    int          lat, nrd, nwr, r0, w0, g;
    logic [31:0] sa, sd;

    function automatic vec_t mk(string n, bit wr, logic [2:0] wd, logic [31:0] a,
                                logic [31:0] d, logic [31:0] er, bit ef, int el, int erd,
                                int ewr);
        vec_t v;
        v.name = n; v.wr = wr; v.width = wd; v.addr = a; v.wdata = d; v.exp_rdata = er;
        v.exp_fault = ef; v.exp_lat = el; v.exp_rd = erd; v.exp_wr = ewr;
        return v;
    endfunction

    initial begin
        vecs.push_back(mk("lw40_miss",    0, 3'b010, 32'h40,  0, 32'h11223344, 0, 0, 4, 0));
        vecs.push_back(mk("sb41",         1, 3'b000, 32'h41,  32'hFF, 0,       0, 2, 0, 0));
        vecs.push_back(mk("lb41",         0, 3'b000, 32'h41,  0, 32'hFFFFFFFF, 0, 2, 0, 0));
        vecs.push_back(mk("lbu41",        0, 3'b100, 32'h41,  0, 32'h000000FF, 0, 2, 0, 0));
        vecs.push_back(mk("lh43_fault",   0, 3'b001, 32'h43,  0, 0,            1, 1, 0, 0));
        vecs.push_back(mk("w011_fault",   0, 3'b011, 32'h40,  0, 0,            1, 1, 0, 0));
        vecs.push_back(mk("lhu42",        0, 3'b101, 32'h42,  0, 32'h00001122, 0, 2, 0, 0));
        vecs.push_back(mk("lh40",         0, 3'b001, 32'h40,  0, 32'hFFFFFF44, 0, 2, 0, 0));
        vecs.push_back(mk("sh46",         1, 3'b001, 32'h46,  32'h8001, 0,     0, 2, 0, 0));
        vecs.push_back(mk("lw44",         0, 3'b010, 32'h44,  0, 32'h80017788, 0, 2, 0, 0));
        vecs.push_back(mk("lw48",         0, 3'b010, 32'h48,  0, 32'h99AABBCC, 0, 2, 0, 0));
        vecs.push_back(mk("sw40",         1, 3'b010, 32'h40,  32'hDEADBEEF, 0, 0, 2, 0, 0));
        vecs.push_back(mk("lw140_evict",  0, 3'b010, 32'h140, 0, init_word(32'h140),
                          0, 0, 4, 4));
        vecs.push_back(mk("lw40_clean",   0, 3'b010, 32'h40,  0, 32'hDEADBEEF, 0, 0, 4, 0));
        vecs.push_back(mk("w110_fault",   0, 3'b110, 32'h40,  0, 0,            1, 1, 0, 0));
        vecs.push_back(mk("w111_fault",   0, 3'b111, 32'h40,  0, 0,            1, 1, 0, 0));
        vecs.push_back(mk("lw42_fault",   0, 3'b010, 32'h42,  0, 0,            1, 1, 0, 0));
        vecs.push_back(mk("sw41_fault",   1, 3'b010, 32'h41,  32'h12345678, 0, 1, 1, 0, 0));
        vecs.push_back(mk("lw40_hit",     0, 3'b010, 32'h40,  0, 32'hDEADBEEF, 0, 2, 0, 0));
        vecs.push_back(mk("lbu43",        0, 3'b100, 32'h43,  0, 32'h000000DE, 0, 2, 0, 0));
        vecs.push_back(mk("lb42",         0, 3'b000, 32'h42,  0, 32'hFFFFFFAD, 0, 2, 0, 0));
        vecs.push_back(mk("lh42",         0, 3'b001, 32'h42,  0, 32'hFFFFDEAD, 0, 2, 0, 0));

        reset_dut();
        chk("rst_req_ready", {31'b0, req_ready}, 32'd1);
        chk("rst_resp_valid", {31'b0, resp_valid}, 32'd0);
        chk("rst_resp_fault", {31'b0, resp_fault}, 32'd0);
        chk("rst_resp_rdata", resp_rdata, 32'd0);
        chk("rst_mem_valid", {31'b0, mem_valid}, 32'd0);
        chk("rst_mem_write", {31'b0, mem_write}, 32'd0);

        r0 = rd_log.size(); w0 = wr_log.size();
        foreach (vecs[i]) begin
            do_req(vecs[i].wr, vecs[i].width, vecs[i].addr, vecs[i].wdata, rd, flt, lat, nrd,
                   nwr);
            chk({vecs[i].name, "_rdata"}, rd, vecs[i].exp_rdata);
            chk({vecs[i].name, "_fault"}, {31'b0, flt}, {31'b0, vecs[i].exp_fault});
            chk({vecs[i].name, "_rd_beats"}, nrd, vecs[i].exp_rd);
            chk({vecs[i].name, "_wr_beats"}, nwr, vecs[i].exp_wr);
            if (vecs[i].exp_lat != 0) chk({vecs[i].name, "_latency"}, lat, vecs[i].exp_lat);
        end
        if (wr_log.size() >= w0 + 4 && rd_log.size() >= r0 + 12) begin
            for (int k = 0; k < 4; k++) begin
                chk("refill40_addr", rd_log[r0 + k], 32'h40 + 4 * k);
                chk("evict40_addr", wr_log[w0 + k], 32'h40 + 4 * k);
                chk("refill140_addr", rd_log[r0 + 4 + k], 32'h140 + 4 * k);
            end
            chk("evict40_wdata0", wd_log[w0], 32'hDEADBEEF);
            chk("evict44_wdata", wd_log[w0 + 1], 32'h80017788);
        end else begin
            chk("beat_log_size", wr_log.size() - w0, 4);
        end

        // Stall the memory during an eviction and hold it for several cycles.
        reset_dut();
        do_req(1, 3'b010, 32'h80, 32'hCAFEF00D, rd, flt, lat, nrd, nwr);
        w0 = wr_log.size();
        ready_block = 1;
        fork
            do_req(0, 3'b010, 32'h180, 0, rd, flt, lat, nrd, nwr);
            begin
                g = 0;
                while (!(mem_valid && mem_write) && g < 60) begin @(posedge clk); #1; g++; end
                chk("evict_started", {31'b0, mem_valid && mem_write}, 32'd1);
                sa = mem_addr; sd = mem_wdata;
                chk("stall_first_addr", sa, 32'h80);
                repeat (3) begin
                    @(posedge clk); #1;
                    chk("stall_valid", {31'b0, mem_valid}, 32'd1);
                    chk("stall_addr", mem_addr, sa);
                    chk("stall_wdata", mem_wdata, sd);
                end
                ready_block = 0;
            end
        join
        chk("stall_wr_beats", nwr, 4);
        chk("stall_rd_beats", nrd, 4);
        chk("stall_rdata", rd, init_word(32'h180));
        if (wr_log.size() >= w0 + 4) begin
            chk("stall_evict_wdata0", wd_log[w0], 32'hCAFEF00D);
            chk("stall_evict_last_addr", wr_log[w0 + 3], 32'h8C);
        end

        // Reset while a refill is in progress; the line must miss again afterwards.
        reset_dut();
        r0 = rd_log.size();
        req_valid = 1; req_write = 0; req_width = 3'b010; req_addr = 32'h200;
        @(posedge clk); #1 req_valid = 0;
        g = 0;
        while (rd_log.size() == r0 && g < 60) begin @(posedge clk); #1; g++; end
        chk("refill_reached", {31'b0, mem_valid && !mem_write}, 32'd1);
        rst = 1;
        @(posedge clk); #1 rst = 0;
        model_reset();
        chk("midrst_req_ready", {31'b0, req_ready}, 32'd1);
        chk("midrst_mem_valid", {31'b0, mem_valid}, 32'd0);
        chk("midrst_resp_valid", {31'b0, resp_valid}, 32'd0);
        do_req(0, 3'b010, 32'h200, 0, rd, flt, lat, nrd, nwr);
        chk("midrst_remiss_beats", nrd, 4);
        chk("midrst_rdata", rd, init_word(32'h200));

        // Random traffic against the flat-memory reference.
        reset_dut();
        ready_rand = 1;
        for (int i = 0; i < 300; i++) begin
            bit          wr, ef, hit;
            logic [2:0]  wd;
            logic [31:0] a, d, er;
            int          k, ix, erd, ewr;
            logic [23:0] tg;
            wr = 1'($urandom_range(0, 1));
            k  = $urandom_range(0, 9);
            case (k)
                0, 1:    wd = 3'b000;
                2, 8:    wd = 3'b001;
                3, 4, 7: wd = 3'b010;
                5:       wd = 3'b100;
                6:       wd = 3'b101;
                default: wd = (k % 3 == 0) ? 3'b011 : 3'b110;
            endcase
            if (wr && (wd == 3'b100 || wd == 3'b101)) wd = wd & 3'b011;
            a = $urandom_range(0, 1023);
            if ($urandom_range(0, 4) != 0) begin
                if (wd[1:0] == 2'b01) a[0] = 1'b0;
                if (wd == 3'b010) a[1:0] = 2'b00;
            end
            d  = $urandom;
            ef = ref_fault(wd, a);
            ix = (a >> 4) % 16;
            tg = 24'(a >> 8);
            hit = mv[ix] && mt[ix] == tg;
            er  = (ef || wr) ? 32'h0 : ref_load(wd, a);
            erd = (ef || hit) ? 0 : 4;
            ewr = (ef || hit || !(mv[ix] && md[ix])) ? 0 : 4;
            do_req(wr, wd, a, d, rd, flt, lat, nrd, nwr);
            chk("rnd_rdata", rd, er);
            chk("rnd_fault", {31'b0, flt}, {31'b0, ef});
            chk("rnd_rd_beats", nrd, erd);
            chk("rnd_wr_beats", nwr, ewr);
            if (ef) chk("rnd_fault_latency", lat, 1);
            else if (hit) chk("rnd_hit_latency", lat, 2);
            if (!ef) begin
                if (!hit) begin mv[ix] = 1; mt[ix] = tg; md[ix] = 0; end
                if (wr) begin md[ix] = 1; ref_store(wd, a, d); end
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
